// File: rtl/regfile_port_master.sv
// regfile_port_master: command-driven READ/WRITE/DUMP/CLEAR engine driving a 32 x 8 register file
module regfile_port_master #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data_a,
    output logic [DATA_W-1:0] rsp_data_b,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_last,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_a1,
    output logic [ADDR_W-1:0] rf_a2,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd,
    output logic              rf_we,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD       = 3'd1;
    localparam logic [2:0] RSP      = 3'd2;
    localparam logic [2:0] WR       = 3'd3;
    localparam logic [2:0] DUMP_RD  = 3'd4;
    localparam logic [2:0] DUMP_RSP = 3'd5;
    localparam logic [2:0] CLR      = 3'd6;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_a_q, rsp_data_a_d;
    logic [DATA_W-1:0] rsp_data_b_q, rsp_data_b_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic              rsp_last_q, rsp_last_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] rf_a1_q, rf_a1_d;
    logic [ADDR_W-1:0] rf_a2_q, rf_a2_d;
    logic [ADDR_W-1:0] rf_a3_q, rf_a3_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] idx_nxt;

    assign idx_nxt    = idx_q + IDX_ONE;
    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data_a = rsp_data_a_q;
    assign rsp_data_b = rsp_data_b_q;
    assign rsp_addr   = rsp_addr_q;
    assign rsp_last   = rsp_last_q;
    assign busy       = busy_q;
    assign rf_a1      = rf_a1_q;
    assign rf_a2      = rf_a2_q;
    assign rf_a3      = rf_a3_q;
    assign rf_wd      = rf_wd_q;
    assign rf_we      = rf_we_q;

    // Next-state and next-output logic; rf_we defaults low so it only pulses in WR/CLR.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_a_d = rsp_data_a_q;
        rsp_data_b_d = rsp_data_b_q;
        rsp_addr_d   = rsp_addr_q;
        rsp_last_d   = rsp_last_q;
        rf_a1_d      = rf_a1_q;
        rf_a2_d      = rf_a2_q;
        rf_a3_d      = rf_a3_q;
        rf_wd_d      = rf_wd_q;
        rf_we_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    case (cmd_op)
                        2'b00: begin
                            state_d = RD;
                            rf_a1_d = cmd_addr_a;
                            rf_a2_d = cmd_addr_b;
                        end
                        2'b01: begin
                            state_d = WR;
                            rf_a3_d = cmd_addr_a;
                            rf_wd_d = cmd_wdata;
                            rf_we_d = 1'b1;
                        end
                        2'b10: begin
                            state_d = DUMP_RD;
                            idx_d   = '0;
                            rf_a1_d = '0;
                        end
                        default: begin
                            state_d = CLR;
                            idx_d   = '0;
                            rf_a3_d = '0;
                            rf_wd_d = '0;
                            rf_we_d = 1'b1;
                        end
                    endcase
                end
            end
            RD: begin
                state_d      = RSP;
                rsp_data_a_d = rf_rd1;
                rsp_data_b_d = rf_rd2;
                rsp_addr_d   = rf_a1_q;
                rsp_last_d   = 1'b1;
                rsp_valid_d  = 1'b1;
            end
            RSP: begin
                state_d     = rsp_ready ? IDLE : RSP;
                rsp_valid_d = !rsp_ready;
            end
            WR: state_d = IDLE;
            DUMP_RD: begin
                state_d      = DUMP_RSP;
                rsp_data_a_d = rf_rd1;
                rsp_data_b_d = '0;
                rsp_addr_d   = idx_q;
                rsp_last_d   = (idx_q == LAST_IDX);
                rsp_valid_d  = 1'b1;
            end
            DUMP_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = rsp_last_q ? IDLE : DUMP_RD;
                    idx_d       = rsp_last_q ? idx_q : idx_nxt;
                    rf_a1_d     = rsp_last_q ? rf_a1_q : idx_nxt;
                end
            end
            CLR: begin
                // The cycle after the final write runs with rf_we low, giving NUM_REGS+1 busy cycles.
                if (!rf_we_q) begin
                    state_d = IDLE;
                end else if (idx_q != LAST_IDX) begin
                    idx_d   = idx_nxt;
                    rf_a3_d = idx_nxt;
                    rf_we_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and all registered outputs; reset aborts any operation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_a_q <= '0;
            rsp_data_b_q <= '0;
            rsp_addr_q   <= '0;
            rsp_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            rf_a1_q      <= '0;
            rf_a2_q      <= '0;
            rf_a3_q      <= '0;
            rf_wd_q      <= '0;
            rf_we_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_a_q <= rsp_data_a_d;
            rsp_data_b_q <= rsp_data_b_d;
            rsp_addr_q   <= rsp_addr_d;
            rsp_last_q   <= rsp_last_d;
            busy_q       <= busy_d;
            rf_a1_q      <= rf_a1_d;
            rf_a2_q      <= rf_a2_d;
            rf_a3_q      <= rf_a3_d;
            rf_wd_q      <= rf_wd_d;
            rf_we_q      <= rf_we_d;
        end
    end
endmodule

// File: tb/tb_regfile_port_master.sv
// tb_regfile_port_master: directed bench with a command-level model of register contents and expected beats/writes
module tb_regfile_port_master;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int NR = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr_a = '0;
    logic [AW-1:0] cmd_addr_b = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data_a, rsp_data_b;
    logic [AW-1:0] rsp_addr;
    logic          rsp_last, busy;
    logic [AW-1:0] rf_a1, rf_a2, rf_a3;
    logic [DW-1:0] rf_wd, rf_rd1, rf_rd2;
    logic          rf_we;

    logic [DW-1:0] rf [NR];
    logic [DW-1:0] mem_m [NR];
    beat_t         rq[$];
    wr_t           wq[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            acc_cyc = 0;
    int            beats = 0;
    logic          hold = 1'b0;
    logic          prev_we = 1'b0;
    logic          chk_adj = 1'b0;
    beat_t         cur_b, prev_b, last_b, exp_b;
    wr_t           exp_w;

    regfile_port_master #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b), .rsp_addr(rsp_addr), .rsp_last(rsp_last),
        .busy(busy),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_we(rf_we),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
    );

    always #5 clk = ~clk;

    // Environment register file: combinational reads, write on the rising edge.
    assign rf_rd1 = rf[rf_a1];
    assign rf_rd2 = rf[rf_a2];
    always @(posedge clk) if (rf_we) rf[rf_a3] <= rf_wd;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Compare process: every write and every beat handshake checked against the model queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold    = 1'b0;
            prev_we = 1'b0;
        end else begin
            if (rf_we) begin
                check("rf_write_expected", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    exp_w = wq.pop_front();
                    check("rf_a3", 32'(rf_a3), 32'(exp_w.addr));
                    check("rf_wd", 32'(rf_wd), 32'(exp_w.d));
                end
            end
            if (chk_adj) check("rf_we_adjacent", 32'(rf_we & prev_we), 32'd0);
            prev_we = rf_we;
            cur_b = '{rsp_addr, rsp_data_a, rsp_data_b, rsp_last};
            if (hold) check("rsp_stable", 32'(cur_b), 32'(prev_b));
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 32'(rq.size() != 0), 32'd1);
                if (rq.size() != 0) begin
                    exp_b = rq.pop_front();
                    check("rsp_beat", 32'(cur_b), 32'(exp_b));
                    beats++;
                    last_b = cur_b;
                end
            end
            hold   = rsp_valid && !rsp_ready;
            prev_b = cur_b;
        end
    end

    task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [DW-1:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_wdata = d;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                check("cmd_accept_timeout", 32'(n), 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check(nm, 32'(busy), 32'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wq.push_back('{a, d});
        mem_m[a] = d;
        send(2'b01, a, '0, d);
    endtask

    task automatic read_check(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        rq.push_back('{a, mem_m[a], mem_m[b], 1'b1});
        send(2'b00, a, b, '0);
        check("read_valid_e0", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("read_valid_e1", 32'(rsp_valid), 32'd1);
        check("read_data_a", 32'(rsp_data_a), 32'(ea));
        check("read_data_b", 32'(rsp_data_b), 32'(eb));
        check("read_addr", 32'(rsp_addr), 32'(a));
        check("read_last", 32'(rsp_last), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("read_valid_drop", 32'(rsp_valid), 32'd0);
        check("read_ready_back", 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_clear();
        for (int i = 0; i < NR; i++) begin
            wq.push_back('{AW'(i), 8'h00});
            mem_m[i] = 8'h00;
        end
        send(2'b11, '0, '0, '0);
        repeat (NR) @(posedge clk);
        #1;
        check("clr_ready_n", 32'(cmd_ready), 32'd0);
        check("clr_busy_n", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("clr_ready_n1", 32'(cmd_ready), 32'd1);
        check("clr_busy_n1", 32'(busy), 32'd0);
        check("clr_writes_done", 32'(wq.size()), 32'd0);
    endtask

    task automatic do_dump(input logic rnd);
        int n;
        for (int i = 0; i < NR; i++) rq.push_back('{AW'(i), mem_m[i], 8'h00, (i == NR - 1)});
        beats = 0;
        send(2'b10, '0, '0, '0);
        n = 0;
        while (rq.size() != 0 && n < 3000) begin
            rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        rsp_ready = 1'b0;
        check("dump_beats", 32'(beats), 32'(NR));
        check("dump_last_addr", 32'(last_b.addr), 32'(NR - 1));
        check("dump_last_flag", 32'(last_b.last), 32'd1);
        wait_idle("dump_idle");
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_edge", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int i = 0; i < NR; i++) mem_m[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        release_reset();

        // CLEAR aborted by reset while rf_a3 = 10: registers 0..9 are cleared, 10.. untouched.
        for (int i = 0; i < 10; i++) begin
            wq.push_back('{AW'(i), 8'h00});
            mem_m[i] = 8'h00;
        end
        send(2'b11, '0, '0, '0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_rf_we_pre", 32'(rf_we), 32'd1);
        check("abort_idx10", 32'(rf_a3), 32'd10);
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_rf_we", 32'(rf_we), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_writes", 32'(wq.size()), 32'd0);
        repeat (2) @(posedge clk);
        release_reset();

        // WRITE then READ with fixed latency.
        do_write(5'd5, 8'hA5);
        check("write_we_on", 32'(rf_we), 32'd1);
        @(posedge clk); #1;
        check("write_we_off", 32'(rf_we), 32'd0);
        do_write(5'd7, 8'h3C);
        read_check(5'd5, 5'd7, 8'hA5, 8'h3C);

        // READ with response backpressure and a competing command.
        rq.push_back('{5'd7, mem_m[7], mem_m[5], 1'b1});
        send(2'b00, 5'd7, 5'd5, '0);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr_a = 5'd9; cmd_wdata = 8'hEE;
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            check("stall_data_a", 32'(rsp_data_a), 32'h3C);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("stall_done_valid", 32'(rsp_valid), 32'd0);
        check("stall_done_busy", 32'(busy), 32'd0);

        // CLEAR then DUMP of all zeros.
        do_clear();
        do_dump(1'b0);
        check("clr_dump_last_data", 32'(last_b.a), 32'd0);

        // Load r[i] = 3*i, DUMP with random backpressure.
        for (int i = 0; i < NR; i++) do_write(AW'(i), DW'(3 * i));
        @(posedge clk); #1;
        do_dump(1'b1);
        check("load_dump_last_data", 32'(last_b.a), 32'h5D);

        // Back-to-back WRITEs with cmd_valid held high.
        chk_adj = 1'b1;
        do_write(5'd1, 8'h11);
        t0 = acc_cyc;
        do_write(5'd2, 8'h22);
        check("b2b_period_2", 32'(acc_cyc - t0), 32'd2);
        t0 = acc_cyc;
        do_write(5'd3, 8'h33);
        check("b2b_period_3", 32'(acc_cyc - t0), 32'd2);
        t0 = acc_cyc;
        do_write(5'd4, 8'h44);
        check("b2b_period_4", 32'(acc_cyc - t0), 32'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_adj = 1'b0;
        read_check(5'd1, 5'd4, 8'h11, 8'h44);
        do_dump(1'b0);

        check("final_rq_empty", 32'(rq.size()), 32'd0);
        check("final_wq_empty", 32'(wq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_port_master.md
# regfile_port_master

Command-driven access engine that sits on the initiator side of the 32 x 8-bit register file. It owns the file's read-address, write-address, write-data and write-enable lines, and consumes the two combinational read-data lines. It accepts single-register READ/WRITE commands and two bulk operations (DUMP, CLEAR) over a valid/ready command channel. Results return on a valid/ready response channel. It is used by the debug/boot loader path to inspect and initialise architectural state.

## Interface
Parameters:
- DATA_W, 8, register width
- ADDR_W, 5, register address width
- NUM_REGS, 32, register count; must equal 2^ADDR_W

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 READ, 01 WRITE, 10 DUMP, 11 CLEAR
- cmd_addr_a  in  ADDR_W  READ: first register; WRITE: destination
- cmd_addr_b  in  ADDR_W  READ: second register
- cmd_wdata  in  DATA_W  WRITE data
- rsp_valid  out  1  response beat present
- rsp_ready  in  1  consumer accepts beat
- rsp_data_a  out  DATA_W  first read value
- rsp_data_b  out  DATA_W  second read value (0 in DUMP)
- rsp_addr  out  ADDR_W  address of rsp_data_a
- rsp_last  out  1  final beat of a response
- busy  out  1  high in any state other than IDLE
- rf_a1, rf_a2  out  ADDR_W  register-file read addresses
- rf_a3  out  ADDR_W  register-file write address
- rf_wd  out  DATA_W  register-file write data
- rf_we  out  1  register-file write enable
- rf_rd1, rf_rd2  in  DATA_W  register-file read data (combinational from rf_a1/rf_a2)

## Operation
- States: IDLE, RD, RSP, WR, DUMP_RD, DUMP_RSP, CLR.
- All outputs are registered. Async reset clears every output to 0 and forces IDLE. The internal index counter also resets to 0.
- cmd_ready is 1 only in IDLE, and only from the first clk edge after rst_n rises.
- A command is accepted on an edge where cmd_valid && cmd_ready. Operands are latched at that edge; cmd_* are ignored at all other times.
- READ: IDLE→RD, driving rf_a1=addr_a and rf_a2=addr_b.
  - RD: capture rf_rd1→rsp_data_a, rf_rd2→rsp_data_b, rsp_addr=addr_a, rsp_last=1, rsp_valid=1; go to RSP.
  - RSP: hold until rsp_ready, then clear rsp_valid and go to IDLE.
- WRITE: IDLE→WR with rf_a3=addr_a, rf_wd=wdata, rf_we=1. WR lasts exactly one cycle, then IDLE with rf_we=0. No response.
- DUMP: idx=0, then loop DUMP_RD→DUMP_RSP with rf_a1=idx.
  - DUMP_RD: capture rsp_data_a=rf_rd1, rsp_data_b=0, rsp_addr=idx, rsp_last=(idx==NUM_REGS-1), rsp_valid=1.
  - DUMP_RSP: on handshake, if last go to IDLE; else idx+1 and go to DUMP_RD.
  - Exactly NUM_REGS beats, addresses ascending, none dropped or duplicated.
- CLEAR: CLR for NUM_REGS consecutive cycles with rf_we=1, rf_wd=0, rf_a3=idx (0..NUM_REGS-1), then IDLE. No response.
- rf_we is 1 only in WR and CLR. rf_a1/rf_a2/rf_a3 hold their last values when unused.
- While rsp_valid=1 and rsp_ready=0, every rsp_* output is stable.
- Reset mid-operation aborts immediately:
  - rf_we and rsp_valid drop asynchronously.
  - A partially completed CLEAR leaves registers partially cleared.
  - No response is produced for the aborted command.

## Timing
- READ: accept at edge E0 → rsp_valid high after E1 (2-cycle latency). Earliest next accept is on the edge after the rsp handshake.
- WRITE: accept E0 → rf_we high for exactly the cycle E0–E1, and the register file writes at E1. cmd_ready is back at 1 after E1, so back-to-back WRITEs accept every 2 cycles.
- DUMP: first beat valid after E1. The minimum beat period is 2 cycles. Total time is 2·NUM_REGS+1 cycles with rsp_ready held high.
- CLEAR: rf_we is high for cycles E0..E0+NUM_REGS; cmd_ready returns after E0+NUM_REGS+1 (NUM_REGS+1 cycles busy).
- busy = (state != IDLE), registered alongside the state.

## Test plan
- Reset: assert rst_n low during CLEAR at idx=10 → rf_we, rsp_valid and busy are 0 immediately. After release, cmd_ready=0 until the first edge, then 1.
- WRITE r5=0xA5, then READ (5,7) with r7=0x3C → rf_we is high exactly one cycle. Response rsp_data_a=0xA5, rsp_data_b=0x3C, rsp_addr=5, rsp_last=1, valid 2 cycles after accept.
- READ with rsp_ready held low for 5 cycles → all rsp_* stable, cmd_ready=0, a concurrent cmd_valid is not accepted. Handshake on cycle 6 → IDLE.
- CLEAR then DUMP → 32 consecutive rf_we cycles with rf_a3 0..31 and rf_wd=0. DUMP returns 32 beats of 0x00 with rsp_addr 0..31 and rsp_last only on beat 31.
- Load r[i]=3·i mod 256, then DUMP with pseudo-random rsp_ready → beat i carries 3·i, rsp_data_b=0, no drops or duplicates, 32 beats total.
- Back-to-back WRITEs to r1..r4 with cmd_valid held high → accepted every 2 cycles, rf_we never high on two adjacent cycles. A readback via DUMP matches.
